// File: rtl/memory_access_stage.sv
// MEM pipeline stage: drives the data memory over a req/ack handshake, stalls the
// pipeline while an access is outstanding and abandons it after a bounded wait.
module memory_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] FAULT_DATA     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WB_in,
   input  logic        MEM_Read_in,
   input  logic        MEM_Write_in,
   input  logic        CALL_in,
   input  logic [31:0] npc_in,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  R_dest_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        WB_out,
   output logic        MEM_Read_out,
   output logic        CALL_out,
   output logic [31:0] npc_out,
   output logic [31:0] ALU_result_out,
   output logic [31:0] MEM_Data_out,
   output logic [4:0]  R_dest_out,
   output logic        mem_busy,
   output logic        wb_bubble,
   output logic        mem_fault,
   output logic [31:0] fault_addr
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_mem_fault;
   logic [31:0]      r_fault_addr;

   logic [0:0]       w_state_nxt;
   logic [CNT_W-1:0] w_wait_cnt_nxt;
   logic             w_mem_op;
   logic             w_req;
   logic             w_busy;
   logic             w_bubble;
   logic             w_timeout;
   logic [31:0]      w_data;

   assign w_mem_op = MEM_Read_in | MEM_Write_in;

   // Next-state and handshake decode; ack releases the pipeline in the same cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_req          = 1'b0;
      w_busy         = 1'b0;
      w_bubble       = 1'b0;
      w_timeout      = 1'b0;
      w_data         = 32'h0;
      if (reset) begin
         w_bubble       = 1'b1;
         w_state_nxt    = S_IDLE;
         w_wait_cnt_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mem_op) begin
                  w_req = 1'b1;
                  if (dmem_ack) begin
                     w_data = MEM_Write_in ? 32'h0 : dmem_rdata;
                  end else begin
                     w_busy         = 1'b1;
                     w_bubble       = 1'b1;
                     w_state_nxt    = S_WAIT;
                     w_wait_cnt_nxt = CNT_W'(1);
                  end
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  w_req          = 1'b1;
                  w_data         = dmem_rdata;
                  w_state_nxt    = S_IDLE;
                  w_wait_cnt_nxt = '0;
               end else if (r_wait_cnt == TIMEOUT_CNT) begin
                  w_timeout      = 1'b1;
                  w_data         = FAULT_DATA;
                  w_state_nxt    = S_IDLE;
                  w_wait_cnt_nxt = '0;
               end else begin
                  w_req          = 1'b1;
                  w_busy         = 1'b1;
                  w_bubble       = 1'b1;
                  w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt    = S_IDLE;
               w_wait_cnt_nxt = '0;
            end
         endcase
      end
   end

   // State register; the first abandoned address is latched until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         r_mem_fault  <= 1'b0;
         r_fault_addr <= 32'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_timeout) begin
            r_mem_fault <= 1'b1;
            if (!r_mem_fault) begin
               r_fault_addr <= ALU_result_in;
            end
         end
      end
   end

   assign dmem_req       = w_req;
   assign dmem_we        = MEM_Write_in;
   assign dmem_addr      = ALU_result_in;
   assign dmem_wdata     = store_data_in;
   assign mem_busy       = w_busy;
   assign wb_bubble      = w_bubble;
   assign MEM_Data_out   = w_data;
   assign WB_out         = WB_in & ~w_timeout;
   assign MEM_Read_out   = MEM_Read_in;
   assign CALL_out       = CALL_in;
   assign npc_out        = npc_in;
   assign ALU_result_out = ALU_result_in;
   assign R_dest_out     = R_dest_in;
   assign mem_fault      = r_mem_fault;
   assign fault_addr     = r_fault_addr;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_memory_access_stage;

   localparam int unsigned TO = 4;
   localparam logic [31:0] FD = 32'hDEAD_BEEF;

   logic        clk;
   logic        reset;
   logic        wb_in, rd_in, wr_in, call_in;
   logic [31:0] npc_in, alu_in, sd_in;
   logic [4:0]  dest_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        wb_out, rd_out, call_out;
   logic [31:0] npc_out, alu_out, data_out;
   logic [4:0]  dest_out;
   logic        mem_busy, wb_bubble, mem_fault;
   logic [31:0] fault_addr;

   int checks = 0;
   int errors = 0;

   // Model: cycles the current access has already waited, plus the sticky fault record.
   int unsigned m_age   = 0;
   logic        m_fault = 1'b0;
   logic [31:0] m_faddr = 32'h0;

   memory_access_stage #(.TIMEOUT_CYCLES(TO), .FAULT_DATA(FD)) dut (
      .clk(clk), .reset(reset),
      .WB_in(wb_in), .MEM_Read_in(rd_in), .MEM_Write_in(wr_in), .CALL_in(call_in),
      .npc_in(npc_in), .ALU_result_in(alu_in), .store_data_in(sd_in), .R_dest_in(dest_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .WB_out(wb_out), .MEM_Read_out(rd_out), .CALL_out(call_out),
      .npc_out(npc_out), .ALU_result_out(alu_out), .MEM_Data_out(data_out),
      .R_dest_out(dest_out), .mem_busy(mem_busy), .wb_bubble(wb_bubble),
      .mem_fault(mem_fault), .fault_addr(fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input logic wb, input logic rd, input logic wr, input logic call,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest);
      wb_in = wb; rd_in = rd; wr_in = wr; call_in = call;
      alu_in = alu; sd_in = sd; dest_in = dest; npc_in = alu ^ 32'h0000_1004;
   endtask

   task automatic set_mem(input logic ack, input logic [31:0] rdata);
      dmem_ack = ack; dmem_rdata = rdata;
      #3;
   endtask

   // Compare the settled outputs with the model, then advance one clock.
   task automatic tick();
      logic        e_req, e_busy, e_bub, e_wb, e_data_vld;
      logic [31:0] e_data;
      logic        active;
      chk("mem_fault", 32'(mem_fault), 32'(m_fault));
      chk("fault_addr", fault_addr, m_faddr);
      if (reset) begin
         chk("req_rst", 32'(dmem_req), 32'h0);
         chk("busy_rst", 32'(mem_busy), 32'h0);
         chk("bubble_rst", 32'(wb_bubble), 32'h1);
         m_age = 0; m_fault = 1'b0; m_faddr = 32'h0;
      end else begin
         active = (m_age > 0) || rd_in || wr_in;
         e_wb = wb_in; e_data = 32'h0; e_data_vld = 1'b1;
         if (!active) begin
            e_req = 1'b0; e_busy = 1'b0; e_bub = 1'b0; m_age = 0;
         end else if (dmem_ack) begin
            e_req = 1'b1; e_busy = 1'b0; e_bub = 1'b0;
            e_data = (m_age == 0 && wr_in) ? 32'h0 : dmem_rdata;
            m_age = 0;
         end else if (m_age == TO) begin
            e_req = 1'b0; e_busy = 1'b0; e_bub = 1'b0; e_wb = 1'b0; e_data = FD;
            if (!m_fault) m_faddr = alu_in;
            m_fault = 1'b1;
            m_age = 0;
         end else begin
            e_req = 1'b1; e_busy = 1'b1; e_bub = 1'b1; e_data_vld = 1'b0;
            m_age++;
         end
         chk("dmem_req", 32'(dmem_req), 32'(e_req));
         chk("mem_busy", 32'(mem_busy), 32'(e_busy));
         chk("wb_bubble", 32'(wb_bubble), 32'(e_bub));
         chk("WB_out", 32'(wb_out), 32'(e_wb));
         chk("MEM_Read_out", 32'(rd_out), 32'(rd_in));
         chk("CALL_out", 32'(call_out), 32'(call_in));
         chk("npc_out", npc_out, npc_in);
         chk("ALU_result_out", alu_out, alu_in);
         chk("R_dest_out", 32'(dest_out), 32'(dest_in));
         if (e_data_vld) chk("MEM_Data_out", data_out, e_data);
         if (e_req) begin
            chk("dmem_we", 32'(dmem_we), 32'(wr_in));
            chk("dmem_addr", dmem_addr, alu_in);
            chk("dmem_wdata", dmem_wdata, sd_in);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned ack_pct;
      int unsigned k;
      reset = 1'b1;
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      set_mem(1'b0, 32'h0);
      tick();
      set_mem(1'b0, 32'h0);
      tick();
      reset = 1'b0;

      // ALU op passes through with no added latency
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
      set_mem(1'b0, 32'h0);
      chk("lit_rst_fault", 32'(mem_fault), 32'h0);
      chk("lit_rst_faddr", fault_addr, 32'h0);
      chk("lit_alu_wb", 32'(wb_out), 32'h1);
      chk("lit_alu_res", alu_out, 32'h1234);
      chk("lit_alu_dest", 32'(dest_out), 32'd5);
      chk("lit_alu_busy", 32'(mem_busy), 32'h0);
      chk("lit_alu_req", 32'(dmem_req), 32'h0);
      tick();

      // Zero-wait load
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd7);
      set_mem(1'b1, 32'hCAFE_F00D);
      chk("lit_zw_data", data_out, 32'hCAFE_F00D);
      chk("lit_zw_busy", 32'(mem_busy), 32'h0);
      tick();
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 5'd1);
      set_mem(1'b1, 32'h1);
      chk("lit_zw_idle_req", 32'(dmem_req), 32'h0);
      chk("lit_late_ack_data", data_out, 32'h0);
      tick();

      // Load acknowledged in the 4th request cycle
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         set_mem(1'b0, 32'h0);
         chk("lit_3c_busy", 32'(mem_busy), 32'h1);
         chk("lit_3c_bubble", 32'(wb_bubble), 32'h1);
         chk("lit_3c_addr", dmem_addr, 32'h300);
         tick();
      end
      set_mem(1'b1, 32'h1111_2222);
      chk("lit_3c_req", 32'(dmem_req), 32'h1);
      chk("lit_3c_data", data_out, 32'h1111_2222);
      chk("lit_3c_release", 32'(mem_busy), 32'h0);
      tick();

      // Store acknowledged after 2 wait cycles
      set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h55AA_55AA, 5'd0);
      for (int i = 0; i < 2; i++) begin
         set_mem(1'b0, 32'h0);
         chk("lit_st_we", 32'(dmem_we), 32'h1);
         chk("lit_st_busy", 32'(mem_busy), 32'h1);
         chk("lit_st_wdata", dmem_wdata, 32'h55AA_55AA);
         tick();
      end
      set_mem(1'b1, 32'h0);
      chk("lit_st_we_ack", 32'(dmem_we), 32'h1);
      chk("lit_st_release", 32'(mem_busy), 32'h0);
      tick();

      // Two timeouts: the first address is the one recorded
      for (int t = 0; t < 2; t++) begin
         set_op(1'b1, 1'b1, 1'b0, 1'b0, (t == 0) ? 32'h100 : 32'h200, 32'h0, 5'd3);
         for (int i = 0; i < 4; i++) begin
            set_mem(1'b0, 32'h0);
            chk("lit_to_busy", 32'(mem_busy), 32'h1);
            tick();
         end
         set_mem(1'b0, 32'h0);
         chk("lit_to_req", 32'(dmem_req), 32'h0);
         chk("lit_to_wb", 32'(wb_out), 32'h0);
         chk("lit_to_data", data_out, FD);
         chk("lit_to_busy_end", 32'(mem_busy), 32'h0);
         tick();
         set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
         set_mem(1'b0, 32'h0);
         chk("lit_to_fault", 32'(mem_fault), 32'h1);
         chk("lit_to_faddr", fault_addr, 32'h100);
         tick();
      end

      // Reset in the 2nd WAIT cycle abandons the access and clears the fault
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 5'd4);
      set_mem(1'b0, 32'h0);
      tick();
      set_mem(1'b0, 32'h0);
      tick();
      reset = 1'b1;
      set_mem(1'b0, 32'h0);
      chk("lit_rw_req_rst", 32'(dmem_req), 32'h0);
      tick();
      reset = 1'b0;
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd2);
      set_mem(1'b0, 32'h0);
      chk("lit_rw_req", 32'(dmem_req), 32'h0);
      chk("lit_rw_busy", 32'(mem_busy), 32'h0);
      chk("lit_rw_fault", 32'(mem_fault), 32'h0);
      tick();
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 5'd6);
      set_mem(1'b1, 32'h0BAD_CAFE);
      chk("lit_rw_load", data_out, 32'h0BAD_CAFE);
      chk("lit_rw_load_busy", 32'(mem_busy), 32'h0);
      tick();

      // Randomized traffic; EX/MEM fields are held while the model says stalled
      ack_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (m_age == 0) begin
            k = $urandom_range(0, 19);
            if (k < 8)
               set_op(1'($urandom), 1'b0, 1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom));
            else if (k < 13)
               set_op(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom));
            else if (k < 18)
               set_op(1'b0, 1'b0, 1'b1, 1'b0, $urandom, $urandom, 5'($urandom));
            else if (k == 18)
               set_op(1'($urandom), 1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'($urandom));
            else
               set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
            k = $urandom_range(0, 9);
            ack_pct = (k == 0) ? 0 : (k < 5) ? 25 : 70;
         end
         set_mem($urandom_range(0, 99) < ack_pct, $urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
